uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_arb_pkg.sv | 24 ++
 rtl/uart_tx_serializer.sv | 102 ++++++++++
 rtl/uart_tx_arbiter.sv | 105 ++++++++++
 tb/tb_uart_tx_arbiter.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the two-requester UART transmit arbiter.
package uart_arb_pkg;

    localparam int DATA_BITS = 8;
    localparam int BIT_CNT_W = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    typedef logic req_idx_t;

    localparam req_idx_t REQ_S0 = 1'b0;
    localparam req_idx_t REQ_S1 = 1'b1;

    // Round-robin tie break: the requester that was not served last wins.
    function automatic req_idx_t rr_pick(input req_idx_t last_served);
        return ~last_served;
    endfunction

endpackage

// File: rtl/uart_tx_serializer.sv
// 8N1 LSB-first serializer: captures a byte on start and shifts it out with
// a registered line output; busy is high in every state other than IDLE.
module uart_tx_serializer
    import uart_arb_pkg::*;
#(
    parameter int CLK_DIV = 417
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [DATA_BITS-1:0] data,
    output logic                 uart_tx,
    output logic                 busy
);

    localparam int BW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [BW-1:0]        BAUD_RELOAD = BW'(CLK_DIV - 1);
    localparam logic [BIT_CNT_W-1:0] LAST_BIT    = BIT_CNT_W'(DATA_BITS - 1);

    state_t                 state_r;
    logic [BW-1:0]          baud_cnt_r;
    logic [BIT_CNT_W-1:0]   bit_cnt_r;
    logic [DATA_BITS-1:0]   shift_r;
    logic                   tx_r;
    logic                   busy_r;
    logic                   bit_end_s;

    assign bit_end_s = (baud_cnt_r == {BW{1'b0}});

    // Frame sequencer: baud counter reloads at every bit boundary.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            baud_cnt_r <= {BW{1'b0}};
            bit_cnt_r  <= {BIT_CNT_W{1'b0}};
            shift_r    <= {DATA_BITS{1'b0}};
            tx_r       <= 1'b1;
            busy_r     <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        state_r    <= START;
                        baud_cnt_r <= BAUD_RELOAD;
                        shift_r    <= data;
                        tx_r       <= 1'b0;
                        busy_r     <= 1'b1;
                    end else begin
                        tx_r   <= 1'b1;
                        busy_r <= 1'b0;
                    end
                end
                START: begin
                    if (bit_end_s) begin
                        state_r    <= DATA;
                        baud_cnt_r <= BAUD_RELOAD;
                        tx_r       <= shift_r[0];
                        shift_r    <= {1'b0, shift_r[DATA_BITS-1:1]};
                    end else begin
                        baud_cnt_r <= baud_cnt_r - BW'(1);
                    end
                end
                DATA: begin
                    if (bit_end_s) begin
                        baud_cnt_r <= BAUD_RELOAD;
                        // Counter wraps 7->0 on the exit to STOP.
                        bit_cnt_r  <= bit_cnt_r + 3'd1;
                        if (bit_cnt_r == LAST_BIT) begin
                            state_r <= STOP;
                            tx_r    <= 1'b1;
                        end else begin
                            tx_r    <= shift_r[0];
                            shift_r <= {1'b0, shift_r[DATA_BITS-1:1]};
                        end
                    end else begin
                        baud_cnt_r <= baud_cnt_r - BW'(1);
                    end
                end
                STOP: begin
                    if (bit_end_s) begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                        tx_r    <= 1'b1;
                    end else begin
                        baud_cnt_r <= baud_cnt_r - BW'(1);
                    end
                end
                default: begin
                    state_r    <= IDLE;
                    baud_cnt_r <= {BW{1'b0}};
                    bit_cnt_r  <= {BIT_CNT_W{1'b0}};
                    tx_r       <= 1'b1;
                    busy_r     <= 1'b0;
                end
            endcase
        end
    end

    assign uart_tx = tx_r;
    assign busy    = busy_r;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Two-requester UART transmitter: round-robin byte arbitration with a
// packet lock that keeps the line owned until the requester's last byte.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int CLK_DIV = 417
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] s0_data,
    input  logic                 s0_valid,
    input  logic                 s0_last,
    output logic                 s0_ready,
    input  logic [DATA_BITS-1:0] s1_data,
    input  logic                 s1_valid,
    input  logic                 s1_last,
    output logic                 s1_ready,
    output logic                 uart_tx,
    output logic                 busy,
    output logic                 grant,
    output logic                 locked
);

    req_idx_t               last_served_r;
    req_idx_t               grant_r;
    logic                   locked_r;

    logic                   s0_ready_s;
    logic                   s1_ready_s;
    logic                   start_s;
    req_idx_t               xfer_idx_s;
    logic [DATA_BITS-1:0]   xfer_data_s;
    logic                   xfer_last_s;
    logic                   ser_busy_s;

    // Ready selection: at most one requester, only while the serializer idles.
    always_comb begin
        s0_ready_s = 1'b0;
        s1_ready_s = 1'b0;
        if (rst || ser_busy_s) begin
            s0_ready_s = 1'b0;
            s1_ready_s = 1'b0;
        end else if (locked_r) begin
            if (grant_r == REQ_S0) begin
                s0_ready_s = s0_valid;
            end else begin
                s1_ready_s = s1_valid;
            end
        end else if (s0_valid && s1_valid) begin
            if (rr_pick(last_served_r) == REQ_S0) begin
                s0_ready_s = 1'b1;
            end else begin
                s1_ready_s = 1'b1;
            end
        end else begin
            s0_ready_s = s0_valid;
            s1_ready_s = s1_valid;
        end
    end

    // Transfer detection and byte mux toward the serializer.
    always_comb begin
        start_s = (s0_valid && s0_ready_s) || (s1_valid && s1_ready_s);
        if (s1_ready_s) begin
            xfer_idx_s  = REQ_S1;
            xfer_data_s = s1_data;
            xfer_last_s = s1_last;
        end else begin
            xfer_idx_s  = REQ_S0;
            xfer_data_s = s0_data;
            xfer_last_s = s0_last;
        end
    end

    // Ownership, lock and round-robin pointer, updated on every transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            locked_r      <= 1'b0;
            grant_r       <= REQ_S0;
            last_served_r <= REQ_S1;
        end else if (start_s) begin
            locked_r      <= ~xfer_last_s;
            grant_r       <= xfer_idx_s;
            last_served_r <= xfer_idx_s;
        end
    end

    uart_tx_serializer #(
        .CLK_DIV (CLK_DIV)
    ) u_ser (
        .clk     (clk),
        .rst     (rst),
        .start   (start_s),
        .data    (xfer_data_s),
        .uart_tx (uart_tx),
        .busy    (ser_busy_s)
    );

    assign s0_ready = s0_ready_s;
    assign s1_ready = s1_ready_s;
    assign busy     = ser_busy_s;
    assign grant    = grant_r;
    assign locked   = locked_r;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter at CLK_DIV=4 with hand-derived frames.
module tb_uart_tx_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] s0_data = 8'h00;
    logic       s0_valid = 1'b0;
    logic       s0_last = 1'b0;
    logic       s0_ready;
    logic [7:0] s1_data = 8'h00;
    logic       s1_valid = 1'b0;
    logic       s1_last = 1'b0;
    logic       s1_ready;
    logic       uart_tx;
    logic       busy;
    logic       grant;
    logic       locked;

    int err_cnt = 0;
    int chk_cnt = 0;
    int cyc = 0;

    uart_tx_arbiter #(.CLK_DIV(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .s0_data  (s0_data),
        .s0_valid (s0_valid),
        .s0_last  (s0_last),
        .s0_ready (s0_ready),
        .s1_data  (s1_data),
        .s1_valid (s1_valid),
        .s1_last  (s1_last),
        .s1_ready (s1_ready),
        .uart_tx  (uart_tx),
        .busy     (busy),
        .grant    (grant),
        .locked   (locked)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        s0_valid = 1'b0;
        s1_valid = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Returns 0/1 for the requester that sees ready, -1 on timeout.
    task automatic wait_ready(input int limit, output int who);
        who = -1;
        for (int i = 0; i < limit; i++) begin
            #1;
            if (s0_ready) begin
                who = 0;
                break;
            end else if (s1_ready) begin
                who = 1;
                break;
            end
            tick();
        end
    endtask

    // Expected 8N1 line for CLK_DIV=4 over 41 cycles from the first START cycle.
    function automatic logic [40:0] exp_tx(input logic [7:0] b);
        logic [40:0] v;
        for (int c = 0; c < 41; c++) begin
            if (c < 4)       v[c] = 1'b0;
            else if (c < 36) v[c] = b[(c - 4) / 4];
            else             v[c] = 1'b1;
        end
        return v;
    endfunction

    // Samples 41 cycles starting at the first START cycle.
    task automatic run_frame(input string tag, input logic [7:0] b);
        logic [40:0] tx_v;
        logic [40:0] bsy_v;
        logic [40:0] bsy_e;
        for (int c = 0; c < 41; c++) begin
            tx_v[c]  = uart_tx;
            bsy_v[c] = busy;
            bsy_e[c] = (c < 40);
            if (c < 40) tick();
        end
        chk({tag, "_tx"}, {23'd0, tx_v}, {23'd0, exp_tx(b)});
        chk({tag, "_busy"}, {23'd0, bsy_v}, {23'd0, bsy_e});
    endtask

    initial begin
        int who;
        int f_start [4];
        int seen_rdy;
        int seen_low;

        // Reset state, with a valid offered while rst is high.
        s0_data = 8'hA5; s0_last = 1'b1; s0_valid = 1'b1;
        tick();
        tick();
        chk("rst_ready0", {63'd0, s0_ready}, 64'd0);
        chk("rst_tx", {63'd0, uart_tx}, 64'd1);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_locked", {63'd0, locked}, 64'd0);
        chk("rst_grant", {63'd0, grant}, 64'd0);

        // Single byte 0xA5 from s0; data changes after transfer must not leak.
        rst = 1'b0;
        wait_ready(20, who);
        chk("a5_who", 64'(who), 64'd0);
        tick();
        s0_valid = 1'b0;
        s0_data = 8'hFF;
        run_frame("a5", 8'hA5);
        chk("a5_locked", {63'd0, locked}, 64'd0);
        chk("a5_grant", {63'd0, grant}, 64'd0);

        // Both valid continuously: round-robin s0,s1,s0,s1, 41 cycles apart.
        do_reset();
        s0_data = 8'h5A; s0_last = 1'b1; s0_valid = 1'b1;
        s1_data = 8'hC3; s1_last = 1'b1; s1_valid = 1'b1;
        for (int f = 0; f < 4; f++) begin
            wait_ready(60, who);
            chk("rr_who", 64'(who), 64'(f % 2));
            tick();
            f_start[f] = cyc;
            chk("rr_grant", {63'd0, grant}, 64'(f % 2));
            run_frame("rr", (f % 2 == 0) ? 8'h5A : 8'hC3);
            if (f > 0) chk("rr_period", 64'(f_start[f] - f_start[f-1]), 64'd41);
        end
        s0_valid = 1'b0;
        s1_valid = 1'b0;

        // s1 packet 11,22,33 holds the line against a waiting s0.
        do_reset();
        s1_data = 8'h11; s1_last = 1'b0; s1_valid = 1'b1;
        wait_ready(20, who);
        chk("pk1_who", 64'(who), 64'd1);
        tick();
        s1_data = 8'h22;
        s0_data = 8'h77; s0_last = 1'b1; s0_valid = 1'b1;
        chk("pk1_locked", {63'd0, locked}, 64'd1);
        chk("pk1_grant", {63'd0, grant}, 64'd1);
        run_frame("pk1", 8'h11);
        wait_ready(60, who);
        chk("pk2_who", 64'(who), 64'd1);
        tick();
        s1_data = 8'h33; s1_last = 1'b1;
        run_frame("pk2", 8'h22);
        wait_ready(60, who);
        chk("pk3_who", 64'(who), 64'd1);
        tick();
        s1_valid = 1'b0;
        chk("pk3_unlock", {63'd0, locked}, 64'd0);
        run_frame("pk3", 8'h33);
        wait_ready(60, who);
        chk("pk_s0_who", 64'(who), 64'd0);
        tick();
        s0_valid = 1'b0;
        run_frame("pk_s0", 8'h77);

        // Reset during data bit 3 of 0x0F aborts the frame and the lock.
        do_reset();
        s0_data = 8'h0F; s0_last = 1'b0; s0_valid = 1'b1;
        wait_ready(20, who);
        chk("ab_who", 64'(who), 64'd0);
        tick();
        s0_valid = 1'b0;
        chk("ab_locked", {63'd0, locked}, 64'd1);
        repeat (17) tick();
        chk("ab_bit3", {63'd0, uart_tx}, 64'd1);
        rst = 1'b1;
        tick();
        chk("ab_tx", {63'd0, uart_tx}, 64'd1);
        chk("ab_busy", {63'd0, busy}, 64'd0);
        chk("ab_unlock", {63'd0, locked}, 64'd0);
        rst = 1'b0;
        s1_data = 8'h0F; s1_last = 1'b1; s1_valid = 1'b1;
        wait_ready(20, who);
        chk("ab_next_who", 64'(who), 64'd1);
        tick();
        s1_valid = 1'b0;
        run_frame("ab_next", 8'h0F);

        // Locked owner drops valid: s0 stays blocked, line stays idle.
        do_reset();
        s1_data = 8'h44; s1_last = 1'b0; s1_valid = 1'b1;
        wait_ready(20, who);
        chk("lk_who", 64'(who), 64'd1);
        tick();
        s1_valid = 1'b0;
        s0_data = 8'h99; s0_last = 1'b1; s0_valid = 1'b1;
        run_frame("lk", 8'h44);
        seen_rdy = 0;
        seen_low = 0;
        for (int i = 0; i < 100; i++) begin
            #1;
            if (s0_ready) seen_rdy++;
            if (!uart_tx) seen_low++;
            tick();
        end
        chk("lk_s0_ready", 64'(seen_rdy), 64'd0);
        chk("lk_line_low", 64'(seen_low), 64'd0);
        chk("lk_held", {63'd0, locked}, 64'd1);
        chk("lk_grant", {63'd0, grant}, 64'd1);
        s1_data = 8'h55; s1_last = 1'b1; s1_valid = 1'b1;
        wait_ready(20, who);
        chk("lk_end_who", 64'(who), 64'd1);
        tick();
        s1_valid = 1'b0;
        chk("lk_end_unlock", {63'd0, locked}, 64'd0);
        run_frame("lk_end", 8'h55);
        wait_ready(60, who);
        chk("lk_s0_who", 64'(who), 64'd0);
        tick();
        s0_valid = 1'b0;
        run_frame("lk_s0", 8'h99);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
